// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : Operand/result bus and Start/Busy/Done handshake for serial_adder
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output Start, A, B, Cin,
        input  Busy, Done, Sum, Cout
    );

    modport slave (
        input  Start, A, B, Cin,
        output Busy, Done, Sum, Cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, one full-adder cell reused over WIDTH
//            cycles with a registered carry between bit positions.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_adder_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_q,     w_a_d;
    logic [WIDTH-1:0] r_b_q,     w_b_d;
    logic [WIDTH-1:0] r_res_q,   w_res_d;
    logic             r_carry_q, w_carry_d;
    logic [CW-1:0]    r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_sum_q,   w_sum_d;
    logic             r_cout_q,  w_cout_d;

    // Full-adder cell: two half adders, carries merged by an OR
    logic w_h1_s, w_h1_c, w_fa_s, w_h2_c, w_fa_c;
    assign w_h1_s = r_a_q[0] ^ r_b_q[0];
    assign w_h1_c = r_a_q[0] & r_b_q[0];
    assign w_fa_s = w_h1_s ^ r_carry_q;
    assign w_h2_c = w_h1_s & r_carry_q;
    assign w_fa_c = w_h1_c | w_h2_c;

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_carry_d = r_carry_q;
        w_cnt_d   = r_cnt_q;
        w_sum_d   = r_sum_q;
        w_cout_d  = r_cout_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    w_a_d     = bus.A;
                    w_b_d     = bus.B;
                    w_carry_d = bus.Cin;
                    w_res_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_RUN: begin
                w_a_d     = r_a_q >> 1;
                w_b_d     = r_b_q >> 1;
                w_res_d   = {w_fa_s, r_res_q[WIDTH-1:1]};
                w_carry_d = w_fa_c;
                if (r_cnt_q == C_LAST) begin
                    // Final bit: publish the full result including this bit
                    w_cnt_d   = '0;
                    w_sum_d   = w_res_d;
                    w_cout_d  = w_fa_c;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_carry_q <= 1'b0;
            r_cnt_q   <= '0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_carry_q <= w_carry_d;
            r_cnt_q   <= w_cnt_d;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
        end
    end

    assign bus.Busy = (r_state_q == S_RUN);
    assign bus.Done = (r_state_q == S_DONE);
    assign bus.Sum  = r_sum_q;
    assign bus.Cout = r_cout_q;
endmodule
`default_nettype wire
